// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter for the shared UART transmit path
//
// Purpose: lets NREQ requesters share one uart core write port. A requester
// owns the port for a whole packet; after the last byte a fixed idle gap is
// inserted before the next round-robin decision.
//
// Ports:
//   PCLK, PRESET      clock, asynchronous active-high reset
//   REQ/LAST/DATA     per-requester byte valid, end-of-packet, byte (packed)
//   ACK               combinational; requester's byte is taken at this edge
//   GNT               registered one-hot owner, zero when no owner
//   TX_FULL           uart transmit FIFO full
//   WR_UART/W_DATA    registered write strobe and byte to the uart core
//   BUSY              registered, high whenever the arbiter is not idle
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int BITWIDTH   = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ-1:0]          LAST,
    input  logic [NREQ*BITWIDTH-1:0] DATA,
    output logic [NREQ-1:0]          ACK,
    output logic [NREQ-1:0]          GNT,
    input  logic                     TX_FULL,
    output logic                     WR_UART,
    output logic [BITWIDTH-1:0]      W_DATA,
    output logic                     BUSY
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic                  wr_q, wr_d;
    logic [BITWIDTH-1:0]   wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic [GW-1:0]         gap_q, gap_d;

    logic [BITWIDTH-1:0]   data_arr [NREQ];
    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [PW-1:0]         cand;
    logic                  accept;
    logic [PW-1:0]         owner_inc;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign data_arr[g] = DATA[BITWIDTH*g +: BITWIDTH];
    end

    // First requesting index at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_inc = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

    // Only the owner can be acknowledged, and only while the uart has room.
    assign accept = (state_q == ST_SEND) && REQ[owner_q] && !TX_FULL;
    assign ACK    = accept ? gnt_q : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    wr_d    = 1'b1;
                    wdata_d = data_arr[owner_q];
                    if (LAST[owner_q]) begin
                        gnt_d = '0;
                        ptr_d = owner_inc;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            // Bubble so TX_FULL can reflect the write just issued.
            ST_HOLD: state_d = ST_SEND;
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            gap_q   <= gap_d;
        end
    end

    assign GNT     = gnt_q;
    assign WR_UART = wr_q;
    assign W_DATA  = wdata_q;
    assign BUSY    = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (wr_uart / w_data / tx_full of the uart core) among NREQ on-chip requesters.
- Requesters submit byte packets. A grant is round-robin and locked for a whole packet, so bytes from different requesters never interleave.
- After each packet the block inserts a programmable idle gap, then re-arbitrates.
- Sits between the requesters and the uart core, alongside the APB slave.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BITWIDTH, 8, byte width of each requester's data and of W_DATA.
- GAP_CYCLES, 2, PCLK cycles of forced idle after each packet's last byte (0 allowed).

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- REQ  input  NREQ  REQ[i]=1: requester i has a valid byte on its DATA slice.
- LAST  input  NREQ  LAST[i]=1: requester i's current byte ends its packet.
- DATA  input  NREQ*BITWIDTH  requester i byte at [BITWIDTH*i+BITWIDTH-1 : BITWIDTH*i].
- ACK  output  NREQ  combinational; ACK[i]=1 means requester i's byte is consumed at this edge.
- GNT  output  NREQ  registered one-hot current owner; all-zero when no owner.
- TX_FULL  input  1  uart transmit FIFO full flag.
- WR_UART  output  1  registered one-cycle write strobe to the uart core.
- W_DATA  output  BITWIDTH  registered byte to the uart core, valid while WR_UART=1.
- BUSY  output  1  registered; 1 whenever state is not IDLE.

Behaviour:

Reset values (PRESET=1, asynchronous):
- State IDLE; round-robin pointer = 0.
- GNT=0, WR_UART=0, W_DATA=0, BUSY=0.
- ACK=0 as a consequence of IDLE.

State machine (states IDLE, SEND, HOLD, GAP):
- IDLE:
  - If any REQ bit is set, select the first set bit searching upward from the pointer, wrapping modulo NREQ.
  - Next edge: GNT = one-hot of the winner, state = SEND.
  - No ACK is issued in IDLE.
- SEND:
  - ACK[o] = REQ[o] & ~TX_FULL, where o is the owner; all other ACK bits are 0.
  - On an accepted beat, next edge: WR_UART=1, W_DATA = DATA slice o, then:
    - LAST[o]=0 → state HOLD.
    - LAST[o]=1 → GNT=0, pointer = (o+1) mod NREQ, state GAP (or IDLE if GAP_CYCLES=0).
  - No acceptance: WR_UART=0, W_DATA holds its value, state stays SEND.
- HOLD:
  - One-cycle bubble so TX_FULL reflects the write just issued. ACK=0, WR_UART=0.
  - Next edge → SEND.
  - Peak throughput is 1 byte per 2 cycles.
- GAP:
  - A counter loads GAP_CYCLES-1 on entry and decrements each cycle. ACK=0, WR_UART=0.
  - At 0 → IDLE.

Latency and ordering:
- REQ rising in IDLE at edge n: GNT at n+1, first ACK during cycle n+1, first WR_UART at n+2.
- Byte order within a packet is preserved.
- The next arbitration decision follows the gap.

Boundary conditions:
- Owner deasserts REQ mid-packet: grant stays locked, no timeout; the block waits in SEND.
- TX_FULL high: the block stalls in SEND with ACK=0, for any duration.
- Several REQ bits set simultaneously: only the round-robin winner is granted; the others wait with ACK=0.
- A lone active requester wins consecutive packets, each separated by GAP_CYCLES idle cycles plus one IDLE cycle.
- LAST on a non-owner is ignored.
- PRESET asserted mid-packet: the in-flight WR_UART is cleared immediately, the packet is abandoned, and the pointer returns to 0.

Test Plan:
1. Single packet: requester 1 sends 0x41,0x42,0x43 (LAST on 0x43), TX_FULL=0, GAP_CYCLES=2.
   - GNT=4'b0010 one cycle after REQ.
   - WR_UART pulses carry 0x41, 0x42, 0x43 on alternate cycles.
   - GNT=0 after the third ACK; BUSY low 2 cycles later.
2. Round-robin: all four REQ asserted with 1-byte packets (LAST=1).
   - Grants in order 0,1,2,3,0.
   - W_DATA stream matches each requester's byte; never two grants at once.
3. Packet lock: requesters 0 and 2 both send 3-byte packets.
   - All three bytes of requester 0 reach W_DATA before any byte of requester 2.
4. Backpressure: TX_FULL held high for 10 cycles during a packet.
   - ACK=0 and WR_UART=0 for those cycles.
   - Transmission resumes the cycle TX_FULL drops; no byte lost or duplicated.
5. Reset mid-packet: PRESET pulsed after the second of four bytes.
   - GNT, WR_UART and BUSY go to 0 asynchronously.
   - After release, requester 0 is granted first if all requesters are requesting.
6. GAP_CYCLES=0 with requester 3 alone sending back-to-back 1-byte packets.
   - Exactly one IDLE cycle between LAST acceptance and the next GNT.
